rs_mul_pipe: RTL and testbench

Parametrised multiply reservation station feeding a fully pipelined multiplier. It sits between dispatch and the common data bus. It holds up to DEPTH RV32M multiply ops (MUL/MULH/MULHSU/MULHU) until both operands are resolved, and captures operand values from NUM_WB writeback ports. It issues at most one op per cycle into a MUL_LAT-stage multiplier, which can accept an op every cycle. A pipeline `flush` discards all stored and in-flight work.

---
 rtl/mul_rs_pkg.sv | 36 +++
 rtl/mul_pipe.sv | 84 ++++++++
 rtl/rs_mul_pipe.sv | 197 +++++++++++++++++++
 tb/tb_rs_mul_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rs_pkg.sv
// Shared types for the multiply reservation station: op codes, the stored entry
// layout and the op-to-multiplier-control decode.
package mul_rs_pkg;

    localparam int unsigned RS_XLEN  = 32;
    localparam int unsigned RS_TAG_W = 5;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // A busy operand keeps its producer tag in src*[RS_TAG_W-1:0].
    typedef struct packed {
        logic                live;
        logic [1:0]          op;
        logic [RS_TAG_W-1:0] tag;
        logic                src1_busy;
        logic [RS_XLEN-1:0]  src1;
        logic                src2_busy;
        logic [RS_XLEN-1:0]  src2;
    } rs_entry_t;

    // Returns {a_signed, b_signed, hi_sel}.
    function automatic logic [2:0] op_decode(input logic [1:0] op);
        logic [2:0] ctl;
        case (op)
            MUL_OP_MULH:   ctl = 3'b111;
            MUL_OP_MULHSU: ctl = 3'b101;
            MUL_OP_MULHU:  ctl = 3'b001;
            default:       ctl = 3'b000;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Fully pipelined (XLEN+1)x(XLEN+1) multiplier; result appears MUL_LAT cycles after
// the op is presented. kill drops every op currently in the pipe.
module mul_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic             hi_sel,
    input  logic [TAG_W-1:0] tag,
    input  logic             kill,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_val
);

    localparam int unsigned PW = 2 * XLEN;

    logic signed [XLEN:0]     a_ext;
    logic signed [XLEN:0]     b_ext;
    logic signed [PW+1:0]     full_prod;
    logic [1:0]               unused_prod_ext;
    logic [PW-1:0]            prod;

    logic [MUL_LAT-1:0]       vld_q, vld_d;
    logic [MUL_LAT-1:0]       hi_q, hi_d;
    logic [TAG_W-1:0]         tag_q  [MUL_LAT];
    logic [TAG_W-1:0]         tag_d  [MUL_LAT];
    logic [PW-1:0]            prod_q [MUL_LAT];
    logic [PW-1:0]            prod_d [MUL_LAT];

    assign a_ext     = {a_signed & a[XLEN-1], a};
    assign b_ext     = {b_signed & b[XLEN-1], b};
    assign full_prod = a_ext * b_ext;
    assign {unused_prod_ext, prod} = full_prod;

    always_comb begin
        vld_d     = '0;
        hi_d      = '0;
        vld_d[0]  = in_valid;
        hi_d[0]   = hi_sel;
        tag_d[0]  = tag;
        prod_d[0] = prod;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            vld_d[i]  = vld_q[i-1];
            hi_d[i]   = hi_q[i-1];
            tag_d[i]  = tag_q[i-1];
            prod_d[i] = prod_q[i-1];
        end
        if (kill) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            hi_q  <= '0;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                tag_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            hi_q  <= hi_d;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                tag_q[i]  <= tag_d[i];
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign out_valid = vld_q[MUL_LAT-1];
    assign out_tag   = tag_q[MUL_LAT-1];
    assign out_val   = hi_q[MUL_LAT-1] ? prod_q[MUL_LAT-1][PW-1:XLEN]
                                       : prod_q[MUL_LAT-1][XLEN-1:0];

endmodule

// File: rtl/rs_mul_pipe.sv
// Multiply reservation station: holds ops until both operands are known, snoops the
// writeback ports, and issues the oldest-index ready op (or a ready dispatch) per cycle.
module rs_mul_pipe
    import mul_rs_pkg::*;
#(
    parameter int unsigned XLEN    = RS_XLEN,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TAG_W   = RS_TAG_W,
    parameter int unsigned NUM_WB  = 3,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_src1_busy,
    input  logic                       in_src2_busy,
    input  logic [XLEN-1:0]            in_src1,
    input  logic [XLEN-1:0]            in_src2,
    input  logic [NUM_WB-1:0]          wb_en,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic [NUM_WB*XLEN-1:0]     wb_val,
    output logic                       out_valid,
    output logic [TAG_W-1:0]           out_tag,
    output logic [XLEN-1:0]            out_val,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        new_ent;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] rdy;
    logic [XLEN:0]    wk1 [DEPTH];
    logic [XLEN:0]    wk2 [DEPTH];
    logic [XLEN:0]    din1, din2;
    logic             iss_found;
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             accept, bypass, store;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mul_valid;
    logic [1:0]       sel_op;
    logic [XLEN-1:0]  sel_a, sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic [2:0]       sel_ctl;
    logic             unused_op2;

    assign unused_op2 = in_op[2];

    // {hit, value}; iterating downwards lets the lowest-numbered matching port win.
    function automatic logic [XLEN:0] wb_lookup(input logic [TAG_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        for (int k = int'(NUM_WB) - 1; k >= 0; k--) begin
            if (wb_en[k] && wb_tag[k*TAG_W +: TAG_W] == t) begin
                r = {1'b1, wb_val[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            live[i] = ent_q[i].live;
            rdy[i]  = ent_q[i].live && !ent_q[i].src1_busy && !ent_q[i].src2_busy;
            wk1[i]  = wb_lookup(ent_q[i].src1[TAG_W-1:0]);
            wk2[i]  = wb_lookup(ent_q[i].src2[TAG_W-1:0]);
        end
        din1 = wb_lookup(in_src1[TAG_W-1:0]);
        din2 = wb_lookup(in_src2[TAG_W-1:0]);
    end

    always_comb begin
        iss_found = |rdy;
        iss_idx   = '0;
        alloc_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                iss_idx = IDX_W'(i);
            end
            if (!live[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // in_ready looks only at cycle-start occupancy, so a slot freed by this cycle's
    // issue cannot be reused until the next cycle.
    assign in_ready = ~&live;
    assign accept   = in_valid && in_ready && !flush;
    assign bypass   = accept && !in_src1_busy && !in_src2_busy && !iss_found;
    assign store    = accept && !bypass;

    always_comb begin
        new_ent           = '0;
        new_ent.live      = 1'b1;
        new_ent.op        = in_op[1:0];
        new_ent.tag       = in_tag;
        new_ent.src1_busy = in_src1_busy && !din1[XLEN];
        new_ent.src1      = (in_src1_busy && din1[XLEN]) ? din1[XLEN-1:0] : in_src1;
        new_ent.src2_busy = in_src2_busy && !din2[XLEN];
        new_ent.src2      = (in_src2_busy && din2[XLEN]) ? din2[XLEN-1:0] : in_src2;
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_q[i].live && ent_q[i].src1_busy && wk1[i][XLEN]) begin
                ent_d[i].src1_busy = 1'b0;
                ent_d[i].src1      = wk1[i][XLEN-1:0];
            end
            if (ent_q[i].live && ent_q[i].src2_busy && wk2[i][XLEN]) begin
                ent_d[i].src2_busy = 1'b0;
                ent_d[i].src2      = wk2[i][XLEN-1:0];
            end
        end
        if (iss_found) begin
            ent_d[iss_idx].live = 1'b0;
        end
        if (store) begin
            ent_d[alloc_idx] = new_ent;
        end
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_d[i].live = 1'b0;
            end
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(store) - CNT_W'(iss_found);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign count = count_q;

    always_comb begin
        if (iss_found) begin
            sel_op  = ent_q[iss_idx].op;
            sel_a   = ent_q[iss_idx].src1;
            sel_b   = ent_q[iss_idx].src2;
            sel_tag = ent_q[iss_idx].tag;
        end else begin
            sel_op  = in_op[1:0];
            sel_a   = in_src1;
            sel_b   = in_src2;
            sel_tag = in_tag;
        end
        sel_ctl   = op_decode(sel_op);
        mul_valid = (iss_found || bypass) && !flush;
    end

    mul_pipe #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT),
        .TAG_W   (TAG_W)
    ) u_mul_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mul_valid),
        .a         (sel_a),
        .b         (sel_b),
        .a_signed  (sel_ctl[2]),
        .b_signed  (sel_ctl[1]),
        .hi_sel    (sel_ctl[0]),
        .tag       (sel_tag),
        .kill      (flush),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_val   (out_val)
    );

endmodule

// File: tb/tb_rs_mul_pipe.sv
// Directed bench for rs_mul_pipe: expected results are queued at dispatch and a
// negedge monitor checks every out_valid against the queue head (tag, value, cycle).
module tb_rs_mul_pipe;

    localparam int XLEN = 32;
    localparam int TAG_W = 5;
    localparam int NUM_WB = 3;
    localparam int DEPTH = 8;
    localparam int LAT = 3;

    localparam logic [2:0] OP_MUL = 3'b000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic [TAG_W-1:0]        in_tag;
    logic                    in_src1_busy, in_src2_busy;
    logic [XLEN-1:0]         in_src1, in_src2;
    logic [NUM_WB-1:0]       wb_en;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_val;
    logic                    out_valid;
    logic [TAG_W-1:0]        out_tag;
    logic [XLEN-1:0]         out_val;
    logic [3:0]              count;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   c;

    rs_mul_pipe #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .NUM_WB  (NUM_WB),
        .MUL_LAT (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_tag       (in_tag),
        .in_src1_busy (in_src1_busy),
        .in_src2_busy (in_src2_busy),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .wb_en        (wb_en),
        .wb_tag       (wb_tag),
        .wb_val       (wb_val),
        .out_valid    (out_valid),
        .out_tag      (out_tag),
        .out_val      (out_val),
        .count        (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got tag %0d val 0x%0h in cycle %0d, required none",
                         out_tag, out_val, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_tag", 64'(out_tag), 64'(mon_e.tag));
                check("out_val", 64'(out_val), 64'(mon_e.val));
                check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic idle_inputs();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_op        = '0;
        in_tag       = '0;
        in_src1_busy = 1'b0;
        in_src2_busy = 1'b0;
        in_src1      = '0;
        in_src2      = '0;
        wb_en        = '0;
        wb_tag       = '0;
        wb_val       = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic disp(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        input logic b1, input logic [XLEN-1:0] s1,
                        input logic b2, input logic [XLEN-1:0] s2);
        in_valid     = 1'b1;
        in_op        = op;
        in_tag       = tag;
        in_src1_busy = b1;
        in_src1      = s1;
        in_src2_busy = b2;
        in_src2      = s2;
    endtask

    task automatic wb(input int port, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        wb_en[port]                 = 1'b1;
        wb_tag[port*TAG_W +: TAG_W] = tag;
        wb_val[port*XLEN +: XLEN]   = val;
    endtask

    task automatic expect_out(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val,
                              input int at);
        exp_t e;
        e.tag = tag;
        e.val = val;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    logic [2:0]      sg_op  [4] = '{3'b001, 3'b111, 3'b010, 3'b000};
    logic [XLEN-1:0] sg_a   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [XLEN-1:0] sg_b   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002};
    logic [XLEN-1:0] sg_res [4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);

        // Bypass: ready MUL 7x6 on an empty station.
        c = cyc;
        disp(OP_MUL, 5'd3, 1'b0, 32'd7, 1'b0, 32'd6);
        expect_out(5'd3, 32'd42, c + LAT);
        next_cycle();
        check("bypass_count", 64'(count), 64'd0);
        wait_cycles(5);

        // Signedness, back-to-back bypasses; one op sets the ignored in_op[2].
        for (int i = 0; i < 4; i++) begin
            disp(sg_op[i], 5'(10 + i), 1'b0, sg_a[i], 1'b0, sg_b[i]);
            expect_out(5'(10 + i), sg_res[i], cyc + LAT);
            next_cycle();
        end
        wait_cycles(5);

        // Wake-up through wb port 2, with a disabled port carrying the same tag.
        c = cyc;
        disp(OP_MUL, 5'd20, 1'b1, 32'd9, 1'b0, 32'd10);
        next_cycle();
        check("wake_count_stored", 64'(count), 64'd1);
        wb(0, 5'd8, 32'd99);
        next_cycle();
        wb(2, 5'd9, 32'd5);
        wb_tag[TAG_W +: TAG_W] = 5'd9;
        wb_val[XLEN +: XLEN]   = 32'd77;
        expect_out(5'd20, 32'd50, c + 3 + LAT);
        next_cycle();
        check("wake_count_issue_cycle", 64'(count), 64'd1);
        next_cycle();
        check("wake_count_after", 64'(count), 64'd0);
        wait_cycles(5);

        // Port priority on src1 and independent src2 wake-up in the same cycle.
        c = cyc;
        disp(OP_MUL, 5'd19, 1'b1, 32'd6, 1'b1, 32'd7);
        next_cycle();
        wb(1, 5'd6, 32'd4);
        wb(2, 5'd6, 32'd8);
        wb(0, 5'd7, 32'd3);
        expect_out(5'd19, 32'd12, c + 2 + LAT);
        next_cycle();
        wait_cycles(6);

        // Same-cycle capture at dispatch.
        c = cyc;
        disp(OP_MUL, 5'd21, 1'b1, 32'd4, 1'b0, 32'd3);
        wb(0, 5'd4, 32'd3);
        expect_out(5'd21, 32'd9, c + 1 + LAT);
        next_cycle();
        check("capture_count_stored", 64'(count), 64'd1);
        next_cycle();
        check("capture_count_after", 64'(count), 64'd0);
        wait_cycles(5);

        // Fill all eight entries, try a dispatch while full, then broadcast.
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            disp(OP_MUL, 5'(22 + i), 1'b1, 32'd1, 1'b0, 32'(i + 1));
            next_cycle();
        end
        check("full_count", 64'(count), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        disp(OP_MUL, 5'd18, 1'b0, 32'd2, 1'b0, 32'd2);
        next_cycle();
        check("full_count_hold", 64'(count), 64'd8);
        wb(1, 5'd1, 32'd3);
        for (int i = 0; i < 8; i++) begin
            expect_out(5'(22 + i), 32'(3 * (i + 1)), c + 13 + i);
        end
        next_cycle();
        check("first_issue_in_ready", 64'(in_ready), 64'd0);
        check("first_issue_count", 64'(count), 64'd8);
        next_cycle();
        check("after_issue_in_ready", 64'(in_ready), 64'd1);
        check("after_issue_count", 64'(count), 64'd7);
        wait_cycles(14);

        // Flush with three stored entries and two ops in flight.
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            disp(OP_MUL, 5'(5 + i), 1'b1, 32'd2, 1'b0, 32'd1);
            next_cycle();
        end
        disp(OP_MUL, 5'd30, 1'b0, 32'd2, 1'b0, 32'd2);
        next_cycle();
        disp(OP_MUL, 5'd31, 1'b0, 32'd3, 1'b0, 32'd3);
        next_cycle();
        check("preflush_count", 64'(count), 64'd3);
        flush = 1'b1;
        disp(OP_MUL, 5'd17, 1'b0, 32'd4, 1'b0, 32'd4);
        next_cycle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        wb(0, 5'd2, 32'd9);
        next_cycle();
        disp(OP_MUL, 5'd16, 1'b0, 32'd11, 1'b0, 32'd11);
        expect_out(5'd16, 32'd121, cyc + LAT);
        next_cycle();
        check("postflush_count", 64'(count), 64'd0);
        wait_cycles(8);

        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
